// File: rtl/stage4_vmem_seq.sv
// Sequential vector load/store: one bus word per active element, holds while bus_busy, one-cycle WB.
// Define STAGE4_VMEM_STRIDED_EN to honour req_stride; the default build uses unit stride (1<<eew).
module stage4_vmem_seq #(
    parameter int VLEN  = 128,
    parameter int MAXEL = VLEN / 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_load,
    input  logic [31:0]            req_base,
    input  logic [31:0]            req_stride,
    input  logic [1:0]             req_eew,
    input  logic [$clog2(MAXEL):0] req_vl,
    input  logic [MAXEL-1:0]       req_mask,
    input  logic                   req_vm,
    input  logic [VLEN-1:0]        req_vs3,
    input  logic [VLEN-1:0]        req_vd_old,
    input  logic [4:0]             req_vd,
    output logic                   bus_ren,
    output logic                   bus_wen,
    output logic [31:0]            bus_addr,
    output logic [31:0]            bus_wdata,
    output logic [3:0]             bus_byte_en,
    input  logic [31:0]            bus_rdata,
    input  logic                   bus_busy,
    output logic                   vwb_valid,
    output logic [4:0]             vwb_vd,
    output logic [VLEN-1:0]        vwb_data,
    output logic                   stall,
    output logic                   misaligned,
    input  logic                   flush
);
    localparam int IW = $clog2(MAXEL) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB} state_t;
    state_t r_state, w_next;

    logic            r_load;
    logic            r_vm;
    logic [31:0]     r_ea;
    logic [1:0]      r_eew;
    logic [IW-1:0]   r_vl;
    logic [IW-1:0]   r_i;
    logic [MAXEL-1:0] r_mask;
    logic [VLEN-1:0] r_vs3;
    logic [VLEN-1:0] r_buf;
    logic [4:0]      r_vd;

    logic [31:0]     w_stride;
`ifdef STAGE4_VMEM_STRIDED_EN
    logic [31:0]     r_stride;
    assign w_stride = r_stride;
`else
    logic            w_unused_stride;
    assign w_unused_stride = ^req_stride;
    assign w_stride = 32'd1 << r_eew;
`endif

    logic [IW-1:0] w_limit;
    logic          w_in_range, w_active, w_bad_align, w_mis, w_xfer, w_step, w_accept;
    logic [31:0]   w_esh, w_emask, w_st_elem, w_wdata, w_ld_elem;
    logic [4:0]    w_off_sh;
    logic [3:0]    w_be_base, w_be;

    assign w_limit    = IW'(MAXEL >> r_eew);
    assign w_in_range = r_i < w_limit;
    assign w_active   = w_in_range && (r_i < r_vl) && (r_vm || r_mask[r_i[IW-2:0]]);
    assign w_accept   = req_valid && req_ready;

    always_comb begin
        w_bad_align = 1'b0;
        w_emask     = 32'hFFFF_FFFF;
        w_be_base   = 4'b1111;
        unique case (r_eew)
            2'd0: begin w_emask = 32'h0000_00FF; w_be_base = 4'b0001; end
            2'd1: begin w_emask = 32'h0000_FFFF; w_be_base = 4'b0011; w_bad_align = r_ea[0]; end
            2'd2: w_bad_align = (r_ea[1:0] != 2'b00);
            default: w_bad_align = 1'b1;
        endcase
    end

    // eew=3 is reserved and reported as misaligned at the first element regardless of mask/vl
    assign w_mis  = (r_state == S_ACCESS) && w_in_range &&
                    ((r_eew == 2'd3) || (w_active && w_bad_align));
    assign w_xfer = (r_state == S_ACCESS) && w_active && !w_bad_align && !flush;
    assign w_step = (r_state == S_ACCESS) && !flush && w_in_range && !w_mis &&
                    (!w_active || !bus_busy);

    assign w_esh     = 32'({r_i, 3'b000}) << r_eew;
    assign w_off_sh  = {r_ea[1:0], 3'b000};
    assign w_st_elem = 32'(r_vs3 >> w_esh) & w_emask;
    assign w_wdata   = w_st_elem << w_off_sh;
    assign w_ld_elem = (bus_rdata >> w_off_sh) & w_emask;
    assign w_be      = w_be_base << r_ea[1:0];

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_ACCESS;
            S_ACCESS: begin
                if (!w_in_range) w_next = S_WB;
                else if (w_mis)  w_next = S_IDLE;
            end
            S_WB:     w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_comb begin
        req_ready   = (r_state == S_IDLE) && !flush;
        bus_ren     = w_xfer && r_load;
        bus_wen     = w_xfer && !r_load;
        bus_addr    = w_xfer ? {r_ea[31:2], 2'b00} : 32'h0;
        bus_wdata   = (w_xfer && !r_load) ? w_wdata : 32'h0;
        bus_byte_en = w_xfer ? w_be : 4'h0;
        stall       = (r_state != S_IDLE);
        misaligned  = w_mis && !flush;
        vwb_valid   = (r_state == S_WB) && r_load;
        vwb_vd      = r_vd;
        vwb_data    = r_buf;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_load <= 1'b0;
            r_vm   <= 1'b0;
            r_ea   <= '0;
            r_eew  <= '0;
            r_vl   <= '0;
            r_i    <= '0;
            r_mask <= '0;
            r_vs3  <= '0;
            r_buf  <= '0;
            r_vd   <= '0;
`ifdef STAGE4_VMEM_STRIDED_EN
            r_stride <= '0;
`endif
        end else if (w_accept) begin
            r_load <= req_load;
            r_vm   <= req_vm;
            r_ea   <= req_base;
            r_eew  <= req_eew;
            r_vl   <= req_vl;
            r_i    <= '0;
            r_mask <= req_mask;
            r_vs3  <= req_vs3;
            r_buf  <= req_vd_old;
            r_vd   <= req_vd;
`ifdef STAGE4_VMEM_STRIDED_EN
            r_stride <= req_stride;
`endif
        end else if (w_step) begin
            // running address keeps ea = base + i*stride without a multiplier
            r_i  <= r_i + IW'(1);
            r_ea <= r_ea + w_stride;
            if (w_active && r_load)
                r_buf <= (r_buf & ~(VLEN'(w_emask) << w_esh)) | (VLEN'(w_ld_elem) << w_esh);
        end
    end
endmodule

// File: tb/tb_stage4_vmem_seq.sv
// Bench for stage4_vmem_seq: directed scenarios plus randomized ops against a byte-level model.
module tb_stage4_vmem_seq;
    logic         CLK, RST;
    logic         req_valid, req_ready, req_load, req_vm;
    logic [31:0]  req_base, req_stride;
    logic [1:0]   req_eew;
    logic [4:0]   req_vl, req_vd;
    logic [15:0]  req_mask;
    logic [127:0] req_vs3, req_vd_old;
    logic         bus_ren, bus_wen, bus_busy;
    logic [31:0]  bus_addr, bus_wdata, bus_rdata;
    logic [3:0]   bus_byte_en;
    logic         vwb_valid, stall, misaligned, flush;
    logic [4:0]   vwb_vd;
    logic [127:0] vwb_data;

    int n_cmp = 0;
    int n_fail = 0;

    stage4_vmem_seq #(.VLEN(128), .MAXEL(16)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_base(req_base), .req_stride(req_stride), .req_eew(req_eew),
        .req_vl(req_vl), .req_mask(req_mask), .req_vm(req_vm),
        .req_vs3(req_vs3), .req_vd_old(req_vd_old), .req_vd(req_vd),
        .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
        .bus_rdata(bus_rdata), .bus_busy(bus_busy),
        .vwb_valid(vwb_valid), .vwb_vd(vwb_vd), .vwb_data(vwb_data),
        .stall(stall), .misaligned(misaligned), .flush(flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction
    assign bus_rdata = mem_word(bus_addr);

    function automatic logic [68:0] acc_pack(input bit ld, input logic [31:0] a,
                                             input logic [3:0] be, input logic [31:0] wd);
        return {ld, a, be, ld ? 32'h0 : wd};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [68:0]  obs_acc[$];
    int           obs_wb_n, obs_mis_n, obs_wb_cycle, obs_end_cycle;
    logic [127:0] obs_wb_data;
    logic [4:0]   obs_wb_vd;
    logic         obs_ready_end, obs_flush_bus;

    logic [68:0]  exp_acc[$];
    int           exp_mis, exp_wb;
    logic [127:0] exp_wb_data;

    // Accept one request, then run it cycle by cycle until the unit is idle again.
    task automatic run_op(input bit ld, input logic [31:0] base, input logic [31:0] stride,
                          input logic [1:0] eew, input logic [4:0] vl, input logic [15:0] mask,
                          input bit vm, input logic [127:0] vs3, input logic [127:0] vdold,
                          input logic [4:0] vd, input bit rnd_busy, input logic [63:0] busy_mask,
                          input int flush_cyc, input int rst_cyc);
        bit done;
        obs_acc.delete();
        obs_wb_n = 0; obs_mis_n = 0; obs_wb_cycle = -1; obs_end_cycle = -1;
        obs_wb_data = '0; obs_wb_vd = '0; obs_ready_end = 1'b0; obs_flush_bus = 1'b0;
        done = 1'b0;
        @(posedge CLK); #1;
        req_load = ld; req_base = base; req_stride = stride; req_eew = eew; req_vl = vl;
        req_mask = mask; req_vm = vm; req_vs3 = vs3; req_vd_old = vdold; req_vd = vd;
        bus_busy = 1'b0; flush = 1'b0; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            bus_busy = rnd_busy ? ($urandom_range(0, 2) == 0) : ((c < 64) ? busy_mask[c] : 1'b0);
            flush    = (c == flush_cyc);
            RST      = (c == rst_cyc);
            @(negedge CLK);
            if ((bus_ren || bus_wen) && !bus_busy)
                obs_acc.push_back(acc_pack(bus_ren, bus_addr, bus_byte_en, bus_wdata));
            if (flush) obs_flush_bus = bus_ren | bus_wen;
            if (vwb_valid) begin
                obs_wb_n++; obs_wb_data = vwb_data; obs_wb_vd = vwb_vd; obs_wb_cycle = c;
            end
            if (misaligned) obs_mis_n++;
            if (!stall) begin
                obs_end_cycle = c; obs_ready_end = req_ready; done = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        bus_busy = 1'b0; flush = 1'b0; RST = 1'b0;
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL op_timeout: unit still busy after 300 cycles (base %h eew %0d)", base, eew);
        end
    endtask

    // Reference: walk the elements with plain address arithmetic over a byte image of vd.
    task automatic model(input bit ld, input logic [31:0] base, input logic [31:0] st,
                         input logic [1:0] eew, input logic [4:0] vl, input logic [15:0] mask,
                         input bit vm, input logic [127:0] vs3, input logic [127:0] vdold);
        logic [7:0]  res[16];
        logic [31:0] ea, addr, wd, word;
        logic [3:0]  be;
        int nb, n, off;
        exp_acc.delete(); exp_mis = 0; exp_wb = 0;
        for (int j = 0; j < 16; j++) res[j] = vdold[8*j +: 8];
        if (eew == 2'd3) begin
            exp_mis = 1;
            return;
        end
        nb = 1 << eew;
        n  = 16 / nb;
        for (int k = 0; k < n; k++) begin
            if (k < int'(vl) && (vm || mask[k])) begin
                ea  = base + 32'(k) * st;
                off = int'(ea[1:0]);
                if (off % nb != 0) begin
                    exp_mis = 1;
                    return;
                end
                addr = {ea[31:2], 2'b00};
                word = mem_word(addr);
                be = '0; wd = '0;
                for (int b = 0; b < nb; b++) begin
                    be[off+b] = 1'b1;
                    wd[8*(off+b) +: 8] = vs3[8*(k*nb+b) +: 8];
                    if (ld) res[k*nb+b] = word[8*(off+b) +: 8];
                end
                exp_acc.push_back(acc_pack(ld, addr, be, wd));
            end
        end
        exp_wb = ld ? 1 : 0;
        for (int j = 0; j < 16; j++) exp_wb_data[8*j +: 8] = res[j];
    endtask

    task automatic test_reset();
        RST = 1'b1; req_valid = 1'b0; flush = 1'b0; bus_busy = 1'b0;
        req_load = 1'b0; req_base = '0; req_stride = '0; req_eew = '0; req_vl = '0;
        req_mask = '0; req_vm = 1'b1; req_vs3 = '0; req_vd_old = '0; req_vd = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({bus_ren, bus_wen, vwb_valid, stall, misaligned} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {bus_ren, bus_wen, vwb_valid, stall, misaligned});
        end
        n_cmp++;
        if ({bus_addr, bus_wdata, bus_byte_en} !== 68'h0) begin
            n_fail++; $display("FAIL reset_bus: addr %h wdata %h be %b want zeros", bus_addr, bus_wdata, bus_byte_en);
        end
        n_cmp++;
        if (vwb_data !== 128'h0) begin
            n_fail++; $display("FAIL reset_buf: got %h want 0", vwb_data);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_unit_load();
        logic [127:0] vdold, want;
        vdold = rnd128();
        run_op(1'b1, 32'h100, 32'd4, 2'd2, 5'd4, 16'hFFFF, 1'b1, rnd128(), vdold, 5'd7,
               1'b0, 64'h0, -1, -1);
        n_cmp++;
        if (obs_acc.size() !== 4) begin
            n_fail++; $display("FAIL unit_load_count: got %0d want 4", obs_acc.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs_acc[k] !== acc_pack(1'b1, 32'h100 + 32'(4*k), 4'hF, 32'h0)) begin
                n_fail++; $display("FAIL unit_load_acc%0d: got %h want %h", k, obs_acc[k],
                                   acc_pack(1'b1, 32'h100 + 32'(4*k), 4'hF, 32'h0));
            end
        end
        want = {mem_word(32'h10C), mem_word(32'h108), mem_word(32'h104), mem_word(32'h100)};
        n_cmp++;
        if (obs_wb_n !== 1 || obs_wb_cycle !== 6) begin
            n_fail++; $display("FAIL unit_load_wb_timing: count %0d cycle %0d want 1 at 6", obs_wb_n, obs_wb_cycle);
        end
        n_cmp++;
        if (obs_wb_data !== want || obs_wb_vd !== 5'd7) begin
            n_fail++; $display("FAIL unit_load_wb_data: got %h vd %0d want %h vd 7", obs_wb_data, obs_wb_vd, want);
        end
    endtask

    task automatic test_strided_store();
        logic [127:0] vs3;
        logic [31:0]  a;
        logic [68:0]  w;
        vs3 = rnd128();
        run_op(1'b0, 32'h200, 32'd5, 2'd0, 5'd3, 16'h0, 1'b1, vs3, rnd128(), 5'd3,
               1'b0, 64'h0, -1, -1);
        n_cmp++;
        if (obs_acc.size() !== 3) begin
            n_fail++; $display("FAIL store_count: got %0d want 3", obs_acc.size());
        end
        for (int k = 0; k < 3; k++) begin
`ifdef STAGE4_VMEM_STRIDED_EN
            a = 32'h200 + 32'(4*k);
`else
            a = 32'h200;
`endif
            w = acc_pack(1'b0, a, 4'(1 << k), 32'(vs3[8*k +: 8]) << (8*k));
            n_cmp++;
            if (obs_acc[k] !== w) begin
                n_fail++; $display("FAIL store_acc%0d: got %h want %h", k, obs_acc[k], w);
            end
        end
        n_cmp++;
        if (obs_wb_n !== 0 || obs_mis_n !== 0) begin
            n_fail++; $display("FAIL store_nowb: wb %0d mis %0d want 0 0", obs_wb_n, obs_mis_n);
        end
    endtask

    task automatic test_masked_load();
        logic [127:0] vdold, want;
        vdold = rnd128();
        run_op(1'b1, 32'h400, 32'd4, 2'd2, 5'd4, 16'h0005, 1'b0, rnd128(), vdold, 5'd9,
               1'b0, 64'h0, -1, -1);
        n_cmp++;
        if (obs_acc.size() !== 2 || obs_acc[0] !== acc_pack(1'b1, 32'h400, 4'hF, 32'h0) ||
            obs_acc[1] !== acc_pack(1'b1, 32'h408, 4'hF, 32'h0)) begin
            n_fail++; $display("FAIL masked_acc: count %0d first %h second %h want 0x400,0x408",
                               obs_acc.size(), obs_acc[0], obs_acc[1]);
        end
        want = {vdold[127:96], mem_word(32'h408), vdold[63:32], mem_word(32'h400)};
        n_cmp++;
        if (obs_wb_n !== 1 || obs_wb_data !== want) begin
            n_fail++; $display("FAIL masked_wb: count %0d got %h want %h", obs_wb_n, obs_wb_data, want);
        end
    endtask

    task automatic test_misaligned();
        run_op(1'b1, 32'h101, 32'd2, 2'd1, 5'd8, 16'hFFFF, 1'b1, rnd128(), rnd128(), 5'd1,
               1'b0, 64'h0, -1, -1);
        n_cmp++;
        if (obs_mis_n !== 1 || obs_acc.size() !== 0 || obs_wb_n !== 0) begin
            n_fail++; $display("FAIL misaligned: pulses %0d accesses %0d wb %0d want 1 0 0",
                               obs_mis_n, obs_acc.size(), obs_wb_n);
        end
        n_cmp++;
        if (obs_end_cycle !== 2 || obs_ready_end !== 1'b1) begin
            n_fail++; $display("FAIL misaligned_ready: idle at %0d ready %b want 2 1", obs_end_cycle, obs_ready_end);
        end
    endtask

    task automatic test_busy_flush();
        run_op(1'b1, 32'h300, 32'd4, 2'd2, 5'd4, 16'hFFFF, 1'b1, rnd128(), rnd128(), 5'd2,
               1'b0, 64'b11100, 3, -1);
        n_cmp++;
        if (obs_flush_bus !== 1'b0) begin
            n_fail++; $display("FAIL flush_ren: bus request %b in flush cycle want 0", obs_flush_bus);
        end
        n_cmp++;
        if (obs_end_cycle !== 4 || obs_wb_n !== 0) begin
            n_fail++; $display("FAIL flush_idle: idle at %0d wb %0d want 4 0", obs_end_cycle, obs_wb_n);
        end
        n_cmp++;
        if (obs_acc.size() !== 1 || obs_acc[0] !== acc_pack(1'b1, 32'h300, 4'hF, 32'h0)) begin
            n_fail++; $display("FAIL flush_acc: count %0d first %h want 1 access at 0x300", obs_acc.size(), obs_acc[0]);
        end
    endtask

    task automatic test_vl0();
        logic [127:0] vdold;
        vdold = rnd128();
        run_op(1'b1, 32'h500, 32'd1, 2'd0, 5'd0, 16'hFFFF, 1'b1, rnd128(), vdold, 5'd4,
               1'b0, 64'h0, -1, -1);
        n_cmp++;
        if (obs_acc.size() !== 0 || obs_wb_n !== 1 || obs_wb_data !== vdold) begin
            n_fail++; $display("FAIL vl0: accesses %0d wb %0d data %h want 0 1 %h",
                               obs_acc.size(), obs_wb_n, obs_wb_data, vdold);
        end
        n_cmp++;
        if (obs_end_cycle !== 19) begin
            n_fail++; $display("FAIL vl0_len: idle at %0d want 19", obs_end_cycle);
        end
    endtask

    task automatic test_reset_mid();
        run_op(1'b1, 32'h600, 32'd1, 2'd0, 5'd16, 16'hFFFF, 1'b1, rnd128(), rnd128(), 5'd5,
               1'b0, 64'h0, -1, 3);
        n_cmp++;
        if (obs_wb_n !== 0 || obs_end_cycle !== 4 || obs_ready_end !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid: wb %0d idle at %0d ready %b want 0 4 1",
                               obs_wb_n, obs_end_cycle, obs_ready_end);
        end
        n_cmp++;
        if (vwb_data !== 128'h0) begin
            n_fail++; $display("FAIL reset_mid_buf: got %h want 0", vwb_data);
        end
    endtask

    task automatic test_random();
        bit           ld, vm;
        logic [31:0]  base, stride, eff;
        logic [1:0]   eew;
        logic [4:0]   vl, vd;
        logic [15:0]  mask;
        logic [127:0] vs3, vdold;
        for (int t = 0; t < 40; t++) begin
            ld     = $urandom_range(0, 1);
            vm     = $urandom_range(0, 1);
            eew    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            base   = $urandom;
            if ($urandom_range(0, 1) == 0) base[1:0] = 2'b00;
            stride = 32'(int'($urandom_range(0, 24)) - 12);
            vl     = 5'($urandom_range(0, 16));
            mask   = 16'($urandom);
            vd     = 5'($urandom);
            vs3    = rnd128();
            vdold  = rnd128();
`ifdef STAGE4_VMEM_STRIDED_EN
            eff = stride;
`else
            eff = 32'd1 << eew;
`endif
            model(ld, base, eff, eew, vl, mask, vm, vs3, vdold);
            run_op(ld, base, stride, eew, vl, mask, vm, vs3, vdold, vd, 1'b1, 64'h0, -1, -1);
            n_cmp++;
            if (obs_acc.size() !== exp_acc.size()) begin
                n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", t, obs_acc.size(), exp_acc.size());
            end else begin
                for (int k = 0; k < exp_acc.size(); k++) begin
                    n_cmp++;
                    if (obs_acc[k] !== exp_acc[k]) begin
                        n_fail++; $display("FAIL rnd%0d_acc%0d: got %h want %h", t, k, obs_acc[k], exp_acc[k]);
                    end
                end
            end
            n_cmp++;
            if (obs_mis_n !== exp_mis || obs_wb_n !== exp_wb) begin
                n_fail++; $display("FAIL rnd%0d_flags: mis %0d wb %0d want %0d %0d", t,
                                   obs_mis_n, obs_wb_n, exp_mis, exp_wb);
            end
            if (exp_wb == 1) begin
                n_cmp++;
                if (obs_wb_data !== exp_wb_data || obs_wb_vd !== vd) begin
                    n_fail++; $display("FAIL rnd%0d_wb: got %h vd %0d want %h vd %0d", t,
                                       obs_wb_data, obs_wb_vd, exp_wb_data, vd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unit_load();
        test_strided_store();
        test_masked_load();
        test_misaligned();
        test_busy_flush();
        test_vl0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/stage4_vmem_seq.md
STAGE4_VMEM_SEQ -- requirements
Module: stage4_vmem_seq

Interface
REQ-001 SHALL have parameter VLEN, default 128, giving the vector register width in bits.
REQ-002 SHALL have parameter MAXEL, default VLEN/8, giving the maximum element count, which occurs at EEW=8.
REQ-003 SHALL have port CLK, input, 1 bit: the only clock.
REQ-004 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports req_valid/req_ready, input/output, 1 bit each: request handshake from the execute stage; a request is accepted when both are high on a CLK edge.
REQ-006 SHALL have port req_load, input, 1 bit: 1 = vector load, 0 = vector store.
REQ-007 SHALL have port req_base, input, 32 bits: address of element 0.
REQ-008 SHALL have port req_stride, input, 32 bits: signed byte stride between elements.
REQ-009 SHALL have port req_eew, input, 2 bits: element width, 0 = 8 bits, 1 = 16 bits, 2 = 32 bits; the value 3 is reserved.
REQ-010 SHALL have port req_vl, input, $clog2(MAXEL)+1 bits: number of elements.
REQ-011 SHALL have ports req_mask, input, MAXEL bits, and req_vm, input, 1 bit: the v0 mask bits; req_vm = 1 means unmasked.
REQ-012 SHALL have ports req_vs3 (store data) and req_vd_old (old destination value), input, VLEN bits each.
REQ-013 SHALL have port req_vd, input, 5 bits: destination register index.
REQ-014 SHALL have ports bus_ren and bus_wen, output, 1 bit each: data bus read and write requests.
REQ-015 SHALL have ports bus_addr and bus_wdata, output, 32 bits each: word address and write data.
REQ-016 SHALL have port bus_byte_en, output, 4 bits: byte lane enables.
REQ-017 SHALL have ports bus_rdata, input, 32 bits, and bus_busy, input, 1 bit: the bus completes a transfer in the cycle bus_busy is low.
REQ-018 SHALL have ports vwb_valid, output, 1 bit; vwb_vd, output, 5 bits; vwb_data, output, VLEN bits: the vector writeback.
REQ-019 SHALL have port stall, output, 1 bit: high while a request is in flight.
REQ-020 SHALL have port misaligned, output, 1 bit: a one-cycle exception pulse.
REQ-021 SHALL have port flush, input, 1 bit: abort the operation in flight.

Function
REQ-022 SHALL implement the FSM states IDLE, ACCESS, WB.
REQ-023 SHALL assert req_ready only in IDLE; on acceptance SHALL latch every req_* input, clear the element counter i to 0, and enter ACCESS.
REQ-024 SHALL, in ACCESS, skip element i in one cycle with no bus activity when i >= vl, or when req_vm = 0 and mask[i] = 0.
REQ-025 SHALL otherwise, in ACCESS, drive bus_ren (load) or bus_wen (store) with bus_addr = {ea[31:2],2'b00}, where ea = base + i*stride computed modulo 2^32.
REQ-026 SHALL hold all bus outputs stable while bus_busy = 1, and SHALL increment i on the cycle bus_busy = 0.
REQ-027 SHALL form bus_byte_en as (1<<(1<<eew))-1, shifted left by ea[1:0].
REQ-028 SHALL drive bus_wdata as the element data shifted left by 8*ea[1:0].
REQ-029 SHALL, on a load, extract the element as bus_rdata >> 8*ea[1:0], truncate it to EEW, and write it into element slot i of a result buffer.
REQ-030 SHALL preload the result buffer with req_vd_old on acceptance, so that masked-off and tail elements stay undisturbed.
REQ-031 SHALL treat ea as misaligned when (eew=1 and ea[0]) or (eew=2 and ea[1:0]!=0); on the first misaligned active element it SHALL issue no bus access, pulse misaligned for 1 cycle, and return to IDLE with no writeback.
REQ-032 SHALL go from ACCESS to WB once i reaches MAXEL>>eew.
REQ-033 SHALL, in WB, hold vwb_valid = 1 for exactly one cycle, with vwb_vd the latched vd, for loads only; vwb_data is the result buffer. It SHALL then return to IDLE.
REQ-034 SHALL make WB last one cycle with no writeback for stores.
REQ-035 SHALL assert stall = 1 in ACCESS and WB and in no other state.
REQ-036 SHALL treat vl = 0 as all elements skipped: no bus traffic, and a load writes back req_vd_old.
REQ-037 SHALL, on flush in any state, force IDLE on the next edge, deassert bus_ren and bus_wen immediately (combinationally), and produce no writeback; flush takes priority over bus completion in the same cycle.
REQ-038 SHALL treat req_eew = 3 as misaligned at element 0.

Reset
REQ-039 SHALL, on RST = 1 at a CLK edge, enter IDLE, clear i and the buffers, and drive bus_ren = bus_wen = vwb_valid = stall = misaligned = 0, bus_addr = bus_wdata = 0, bus_byte_en = 0.
REQ-040 SHALL let RST mid-operation abandon the transfer in flight, with no writeback.

Configuration
REQ-041 SHALL honour req_stride for address generation when STAGE4_VMEM_STRIDED_EN is defined.
REQ-042 SHALL ignore req_stride when STAGE4_VMEM_STRIDED_EN is undefined, with stride fixed at 1<<eew (unit stride); all other behaviour is identical.

Verification
REQ-043 SHALL cover: unit-stride load, eew=2, vl=4, base=0x100, zero-wait bus -> reads at 0x100..0x10C, vwb_valid on the 6th cycle after acceptance with data equal to the four words.
REQ-044 SHALL cover: store, eew=0, vl=3, stride=5 (STRIDED_EN), base=0x200 -> writes at 0x200 be=0001, 0x204 be=0010, 0x208 be=0100.
REQ-045 SHALL cover: masked load, vm=0, mask=0b0101, vl=4, eew=2 -> accesses to elements 0 and 2 only, with elements 1 and 3 equal to vd_old.
REQ-046 SHALL cover: load eew=1 with base=0x101 -> misaligned pulses once, no bus access, no vwb_valid, req_ready=1 the next cycle.
REQ-047 SHALL cover: bus_busy held high 3 cycles on element 1, with flush asserted in the 2nd of those cycles -> bus_ren=0 in that same cycle, IDLE the next cycle, no writeback.
REQ-048 SHALL cover: vl=0 load -> no bus activity, vwb_data = vd_old.
